// File: rtl/prng_req_arbiter.sv
// Seeding controller and round-robin arbiter for a shared 256-bit xorshift256 generator.
// Latches seeds, pulses the generator set, discards a warm-up run, then hands each
// generator word to at most one requester.
module prng_req_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WARMUP = 16,
  parameter logic [63:0] ZSUB   = 64'h9E37_79B9_7F4A_7C15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reseed,
  input  logic [255:0]      seed_in1,
  input  logic [255:0]      seed_in2,
  output logic [255:0]      gen_seed1,
  output logic [255:0]      gen_seed2,
  output logic              gen_set,
  input  logic [255:0]      gen_result,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [255:0]      rnd_data,
  output logic              seeded
);

  localparam int unsigned DW    = 256;
  localparam int unsigned LW    = 64;
  localparam int unsigned NLANE = DW / LW;
  localparam int unsigned PW    = $clog2(NREQ);
  localparam int unsigned CW    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEED  = 2'd1,
    S_WARM  = 2'd2,
    S_SERVE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [PW-1:0]   r_rr;
  logic [PW-1:0]   w_rr_nxt;
  logic [PW-1:0]   w_k;
  logic [PW-1:0]   w_idx;
  logic [PW:0]     w_sum;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt_nxt;
  logic            w_found;
  logic            w_arb;
  logic [DW-1:0]   w_seed1_sub;

  // State register and warm-up counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; reseed restarts seeding from any state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (reseed) begin
      w_state_nxt = S_SEED;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_SEED: begin
          if (WARMUP > 0) begin
            w_state_nxt = S_WARM;
            w_cnt_nxt   = CW'(WARMUP - 1);
          end else begin
            w_state_nxt = S_SERVE;
          end
        end
        S_WARM: begin
          if (r_cnt == '0) w_state_nxt = S_SERVE;
          else             w_cnt_nxt   = r_cnt - CW'(1);
        end
        S_SERVE: w_state_nxt = S_SERVE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: zero-lane seed substitution and round-robin pick
  always_comb begin
    w_seed1_sub = seed_in1;
    for (int l = 0; l < int'(NLANE); l++) begin
      if ((seed_in1[l*LW +: LW] == '0) && (seed_in2[l*LW +: LW] == '0))
        w_seed1_sub[l*LW +: LW] = ZSUB;
    end

    // Last cycle's grantee is masked so a one-cycle-late req drop cannot double-grant
    w_elig    = req & ~gnt;
    w_gnt_nxt = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    w_sum     = '0;
    w_k       = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      w_sum = {1'b0, r_rr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
      w_k = w_sum[PW-1:0];
      if (!w_found && w_elig[w_k]) begin
        w_found        = 1'b1;
        w_gnt_nxt[w_k] = 1'b1;
        w_idx          = w_k;
      end
    end
    w_rr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
    w_arb    = (r_state == S_SERVE) && !reseed && w_found;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_seed1 <= '0;
      gen_seed2 <= '0;
      gen_set   <= 1'b0;
      gnt       <= '0;
      rnd_data  <= '0;
      seeded    <= 1'b0;
      r_rr      <= '0;
    end else begin
      gen_set <= reseed;
      seeded  <= (w_state_nxt == S_SERVE);
      if (reseed) begin
        gen_seed1 <= w_seed1_sub;
        gen_seed2 <= seed_in2;
      end
      if (w_arb) begin
        gnt      <= w_gnt_nxt;
        rnd_data <= gen_result;
        r_rr     <= w_rr_nxt;
      end else begin
        gnt <= '0;
      end
    end
  end

endmodule
